npc_pipe_ctrl: RTL and testbench
================================

Name: npc_pipe_ctrl

Overview:
- Parametrised next-PC / fetch-address controller for the pipelined MIPS core; successor to the single-cycle PC update logic.
- Holds the fetch PC and selects the next PC from these sources, highest to lowest priority: exception vector, eret, redirect from decode (branch, absolute jump, register jump), sequential increment.
- Adds stall hold, a pending-redirect buffer for redirects that arrive during a stall, an EPC register, and a flush pulse.

Parameters:
- WIDTH, 32, address width in bits; minimum 8.
- RESET_PC, 32'h0000_3000, PC value at reset; WIDTH bits.
- EXC_VEC, 32'h0000_4180, exception entry address; WIDTH bits.
- STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC this cycle.
- br_req  in  1  decode-stage redirect request.
- br_src  in  2  redirect kind: 0 = PC-relative, 1 = absolute, 2 = register, 3 = reserved.
- br_pc  in  WIDTH  PC of the branch instruction.
- ext_num  in  WIDTH  sign-extended offset (src 0) or absolute target (src 1).
- rd1  in  WIDTH  register target (src 2).
- exc_req  in  1  exception request.
- exc_pc  in  WIDTH  PC of the faulting instruction.
- eret  in  1  return from exception.
- pc  out  WIDTH  current fetch PC.
- pc_plus  out  WIDTH  pc + STEP, combinational.
- epc  out  WIDTH  saved exception PC.
- flush  out  1  registered one-cycle pulse after any non-sequential PC load.
- pend_valid  out  1  a redirect is buffered.

Behaviour:
- Reset (synchronous, active-high):
  - pc = RESET_PC, epc = 0, flush = 0, pend_valid = 0, pend_target = 0.
  - reset overrides all other inputs in the same cycle.
- Target computation, all modulo 2^WIDTH:
  - br_src 0: br_pc + STEP + (ext_num << 2).
  - br_src 1: ext_num.
  - br_src 2: rd1.
  - br_src 3: the request is ignored and does not count as a redirect.
- Priority per rising edge (after reset):
  1. exc_req: pc <= EXC_VEC; epc <= exc_pc; pending buffer cleared; flush <= 1. Applies even when stall = 1.
  2. eret: pc <= epc; pending buffer cleared; flush <= 1. Applies even when stall = 1.
  3. stall = 1: pc holds.
     - If br_req is valid, pend_target <= target and pend_valid <= 1.
     - A newer br_req during the stall overwrites the buffered target.
     - flush <= 0.
  4. stall = 0 and br_req valid: pc <= target; pend_valid <= 0; flush <= 1. A live request wins over a buffered one.
  5. stall = 0 and pend_valid: pc <= pend_target; pend_valid <= 0; flush <= 1.
  6. Otherwise: pc <= pc + STEP; flush <= 0.
- Two-state FSM:
  - IDLE -> PEND on stall with a valid br_req.
  - PEND -> IDLE on the first unstalled cycle, or on exc_req / eret.
  - PEND -> PEND on further stall.
- Latency: one cycle from request to the new pc. flush asserts in the same cycle the new pc appears.
- Wrap-around: pc + STEP wraps from 2^WIDTH - STEP to 0 with no error.
- exc_req and eret together: exc_req wins; epc takes exc_pc.
- Reset while in PEND: the buffer is discarded and the next state is IDLE.

Optional Feature:
- Macro: NPC_ALIGN_CHK_EN.
- Defined:
  - Adds output misalign (1 bit).
  - Any computed non-exception target with bits [1:0] != 0 is not loaded. Instead pc <= EXC_VEC, epc <= the offending target, flush <= 1, and misalign pulses for one cycle.
  - Pending targets are checked when they are applied, not when buffered.
- Undefined: no misalign port; targets are loaded unchecked.

Test Plan:
- Sequential: reset for 2 cycles, then 3 free-running cycles -> pc = 3000, 3004, 3008, 300C; flush stays 0.
- Branch: br_req, src 0, br_pc = 3008, ext_num = FFFF_FFFE, no stall -> next pc = 3004, flush = 1 for that cycle.
- Buffered redirect: stall = 1 for 2 cycles with br_req, src 2, rd1 = 3100 in the first cycle -> pc held, pend_valid = 1; after stall drops, pc = 3100, pend_valid = 0.
- Exception and return: exc_req with exc_pc = 3010 while stall = 1 and a redirect is pending -> pc = 4180, epc = 3010, pend_valid = 0; then eret -> pc = 3010.
- Priority and reset: exc_req, eret and br_req together -> pc = 4180; then reset asserted while in PEND -> pc = 3000, pend_valid = 0.
- NPC_ALIGN_CHK_EN defined: br_req, src 1, ext_num = 3102 -> pc = 4180, epc = 3102, misalign pulses for one cycle.

Source files
------------

// File: rtl/npc_pipe_ctrl_if.sv
// Fetch-address controller bundle: decode/exception requests in, fetch PC state out.
// misalign exists only when NPC_ALIGN_CHK_EN is defined.
interface npc_pipe_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             br_req;
  logic [1:0]       br_src;
  logic [WIDTH-1:0] br_pc;
  logic [WIDTH-1:0] ext_num;
  logic [WIDTH-1:0] rd1;
  logic             exc_req;
  logic [WIDTH-1:0] exc_pc;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] epc;
  logic             flush;
  logic             pend_valid;
`ifdef NPC_ALIGN_CHK_EN
  logic             misalign;
`endif

  // Pipeline side: issues requests, observes the fetch PC.
  modport master (
    output stall, br_req, br_src, br_pc, ext_num, rd1, exc_req, exc_pc, eret,
`ifdef NPC_ALIGN_CHK_EN
    input  misalign,
`endif
    input  pc, pc_plus, epc, flush, pend_valid
  );

  // Controller side.
  modport slave (
    input  stall, br_req, br_src, br_pc, ext_num, rd1, exc_req, exc_pc, eret,
`ifdef NPC_ALIGN_CHK_EN
    output misalign,
`endif
    output pc, pc_plus, epc, flush, pend_valid
  );
endinterface

// File: rtl/npc_pipe_ctrl.sv
// Next-PC controller: exception > eret > stall/buffer > live redirect > pending redirect > sequential.
// Optional NPC_ALIGN_CHK_EN diverts misaligned redirect targets to the exception vector.
module npc_pipe_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC  = 32'h0000_4180,
  parameter int               STEP     = 4
) (
  input logic           clk,
  input logic           reset,
  npc_pipe_ctrl_if.slave bus
);

  typedef enum logic {IDLE, PEND} state_e;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] target;
  logic             br_valid;
  logic [WIDTH-1:0] load_addr;

  // Reserved kind (3) is dropped entirely and never counts as a redirect.
  always_comb begin
    target   = '0;
    br_valid = bus.br_req;
    case (bus.br_src)
      2'd0:    target = bus.br_pc + STEP_W + (bus.ext_num << 2);
      2'd1:    target = bus.ext_num;
      2'd2:    target = bus.rd1;
      default: br_valid = 1'b0;
    endcase
  end

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q + STEP_W;
    epc_d         = epc_q;
    pend_target_d = pend_target_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    load_addr     = '0;

    if (bus.exc_req) begin
      pc_d    = EXC_VEC;
      epc_d   = bus.exc_pc;
      state_d = IDLE;
      flush_d = 1'b1;
    end else if (bus.eret) begin
      pc_d    = epc_q;
      state_d = IDLE;
      flush_d = 1'b1;
    end else if (bus.stall) begin
      pc_d = pc_q;
      if (br_valid) begin
        pend_target_d = target;
        state_d       = PEND;
      end
    end else if (br_valid || state_q == PEND) begin
      load_addr = br_valid ? target : pend_target_q;
      state_d   = IDLE;
      flush_d   = 1'b1;
      pc_d      = load_addr;
`ifdef NPC_ALIGN_CHK_EN
      if (load_addr[1:0] != 2'b00) begin
        pc_d       = EXC_VEC;
        epc_d      = load_addr;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      epc_q         <= '0;
      pend_target_q <= '0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      pend_target_q <= pend_target_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus    = pc_q + STEP_W;
  assign bus.epc        = epc_q;
  assign bus.flush      = flush_q;
  assign bus.pend_valid = (state_q == PEND);
`ifdef NPC_ALIGN_CHK_EN
  assign bus.misalign   = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_npc_pipe_ctrl.sv
// Directed bench for npc_pipe_ctrl with default parameters; misalign checks
// follow NPC_ALIGN_CHK_EN.
module tb_npc_pipe_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  npc_pipe_ctrl_if #(.WIDTH(32)) bus ();

  npc_pipe_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall   = 1'b0;
    bus.br_req  = 1'b0;
    bus.br_src  = 2'd0;
    bus.br_pc   = '0;
    bus.ext_num = '0;
    bus.rd1     = '0;
    bus.exc_req = 1'b0;
    bus.exc_pc  = '0;
    bus.eret    = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_pc", bus.pc, 32'h3000);
    check("rst_epc", bus.epc, 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_pend", 32'(bus.pend_valid), 32'h0);
    check("rst_pc_plus", bus.pc_plus, 32'h3004);

    // Free-running increment.
    reset = 1'b0;
    tick(); check("seq1_pc", bus.pc, 32'h3004);
    tick(); check("seq2_pc", bus.pc, 32'h3008);
    tick(); check("seq3_pc", bus.pc, 32'h300C);
    check("seq3_flush", 32'(bus.flush), 32'h0);

    // PC-relative branch: 3008 + 4 + (FFFF_FFFE << 2) = 3004.
    bus.br_req = 1'b1; bus.br_src = 2'd0; bus.br_pc = 32'h3008; bus.ext_num = 32'hFFFF_FFFE;
    tick();
    check("br_rel_pc", bus.pc, 32'h3004);
    check("br_rel_flush", 32'(bus.flush), 32'h1);
    idle_inputs();
    tick();
    check("after_br_pc", bus.pc, 32'h3008);
    check("after_br_flush", 32'(bus.flush), 32'h0);

    // Redirect during a stall is buffered, then applied.
    bus.stall = 1'b1; bus.br_req = 1'b1; bus.br_src = 2'd2; bus.rd1 = 32'h3100;
    tick();
    check("buf1_pc", bus.pc, 32'h3008);
    check("buf1_pend", 32'(bus.pend_valid), 32'h1);
    check("buf1_flush", 32'(bus.flush), 32'h0);
    bus.br_req = 1'b0;
    tick();
    check("buf2_pc", bus.pc, 32'h3008);
    check("buf2_pend", 32'(bus.pend_valid), 32'h1);
    bus.stall = 1'b0;
    tick();
    check("buf_apply_pc", bus.pc, 32'h3100);
    check("buf_apply_pend", 32'(bus.pend_valid), 32'h0);
    check("buf_apply_flush", 32'(bus.flush), 32'h1);

    // Newer stalled request overwrites the buffered one.
    bus.stall = 1'b1; bus.br_req = 1'b1; bus.br_src = 2'd1; bus.ext_num = 32'h3200;
    tick();
    bus.br_src = 2'd2; bus.rd1 = 32'h3300;
    tick();
    idle_inputs();
    tick();
    check("overwrite_pc", bus.pc, 32'h3300);

    // Live request beats buffered one.
    bus.stall = 1'b1; bus.br_req = 1'b1; bus.br_src = 2'd2; bus.rd1 = 32'h3400;
    tick();
    bus.stall = 1'b0; bus.br_src = 2'd1; bus.ext_num = 32'h3500;
    tick();
    check("live_wins_pc", bus.pc, 32'h3500);
    check("live_wins_pend", 32'(bus.pend_valid), 32'h0);

    // Reserved kind is ignored: sequential step, no flush.
    bus.br_src = 2'd3; bus.ext_num = 32'h3800;
    tick();
    check("src3_pc", bus.pc, 32'h3504);
    check("src3_flush", 32'(bus.flush), 32'h0);
    bus.stall = 1'b1;
    tick();
    check("src3_stall_pend", 32'(bus.pend_valid), 32'h0);
    check("src3_stall_pc", bus.pc, 32'h3504);

    // Exception during stall with a pending redirect, then eret.
    bus.br_src = 2'd2; bus.rd1 = 32'h3600;
    tick();
    check("pre_exc_pend", 32'(bus.pend_valid), 32'h1);
    bus.br_req = 1'b0; bus.exc_req = 1'b1; bus.exc_pc = 32'h3010;
    tick();
    check("exc_pc", bus.pc, 32'h4180);
    check("exc_epc", bus.epc, 32'h3010);
    check("exc_pend", 32'(bus.pend_valid), 32'h0);
    check("exc_flush", 32'(bus.flush), 32'h1);
    idle_inputs();
    bus.eret = 1'b1;
    tick();
    check("eret_pc", bus.pc, 32'h3010);
    check("eret_flush", 32'(bus.flush), 32'h1);
    idle_inputs();
    tick();
    check("post_eret_pc", bus.pc, 32'h3014);

    // exc_req, eret and br_req together: exception wins.
    bus.exc_req = 1'b1; bus.exc_pc = 32'h3020; bus.eret = 1'b1;
    bus.br_req = 1'b1; bus.br_src = 2'd1; bus.ext_num = 32'h3900;
    tick();
    check("prio_pc", bus.pc, 32'h4180);
    check("prio_epc", bus.epc, 32'h3020);

    // Reset while PEND discards the buffer.
    idle_inputs();
    bus.stall = 1'b1; bus.br_req = 1'b1; bus.br_src = 2'd2; bus.rd1 = 32'h3700;
    tick();
    check("pend_before_rst", 32'(bus.pend_valid), 32'h1);
    reset = 1'b1;
    tick();
    check("rst_pend_pc", bus.pc, 32'h3000);
    check("rst_pend_valid", 32'(bus.pend_valid), 32'h0);
    check("rst_pend_epc", bus.epc, 32'h0);
    reset = 1'b0;
    idle_inputs();
    tick();
    check("post_rst_pc", bus.pc, 32'h3004);
    check("post_rst_flush", 32'(bus.flush), 32'h0);

    // Wrap-around at the top of the address space.
    bus.br_req = 1'b1; bus.br_src = 2'd1; bus.ext_num = 32'hFFFF_FFFC;
    tick();
    check("wrap_top_pc", bus.pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus", bus.pc_plus, 32'h0);
    idle_inputs();
    tick();
    check("wrap_pc", bus.pc, 32'h0);

    // Misaligned absolute target.
    bus.br_req = 1'b1; bus.br_src = 2'd1; bus.ext_num = 32'h3102;
    tick();
`ifdef NPC_ALIGN_CHK_EN
    check("mis_pc", bus.pc, 32'h4180);
    check("mis_epc", bus.epc, 32'h3102);
    check("mis_pulse", 32'(bus.misalign), 32'h1);
    check("mis_flush", 32'(bus.flush), 32'h1);
    idle_inputs();
    tick();
    check("mis_pulse_end", 32'(bus.misalign), 32'h0);
    check("mis_next_pc", bus.pc, 32'h4184);
`else
    check("unchecked_pc", bus.pc, 32'h3102);
    check("unchecked_flush", 32'(bus.flush), 32'h1);
    idle_inputs();
    tick();
    check("unchecked_next_pc", bus.pc, 32'h3106);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
